// File: rtl/seq_adder_32b_pkg.sv
// Shared constants for the byte-serial 32-bit adder: FSM encoding and byte count.
package seq_adder_32b_pkg;
  localparam int NUM_BYTES = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_adder_32b_csel.sv
// 8-bit carry-select adder: low nibble ripples, high nibble is precomputed for both carries.
module AdderCarrySelect_8b_GL (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_lo;
  logic [4:0] w_hi0;
  logic [4:0] w_hi1;

  assign w_lo  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0, i_cin};
  assign w_hi0 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
  assign w_hi1 = w_hi0 + 5'd1;

  assign o_sum[3:0]           = w_lo[3:0];
  assign {o_cout, o_sum[7:4]} = w_lo[4] ? w_hi1 : w_hi0;
endmodule

// File: rtl/seq_adder_32b.sv
// Byte-serial 32-bit add/subtract: one 8-bit adder is reused over four CALC cycles.
module seq_adder_32b
  import seq_adder_32b_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        sub,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);
  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_res;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic [7:0]         w_a_byte;
  logic [7:0]         w_b_byte;
  logic [7:0]         w_sum;
  logic               w_cout;
  logic               w_last;

  assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
  assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];
  assign w_last   = (r_idx == IDX_W'(NUM_BYTES - 1));

  AdderCarrySelect_8b_GL u_add (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_val)  w_next = CALC;
      CALC:    if (w_last)  w_next = DONE;
      DONE:    if (out_rdy) w_next = IDLE;
      default:              w_next = IDLE;
    endcase
  end

  always_comb begin
    in_rdy  = (r_state == IDLE);
    out_val = (r_state == DONE);
  end

  // B is stored pre-inverted for subtract; the carry register supplies the +1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_val) begin
          r_a     <= in0;
          r_b     <= sub ? ~in1 : in1;
          r_carry <= sub;
          r_idx   <= '0;
        end
        CALC: begin
          r_res[{r_idx, 3'b000} +: 8] <= w_sum;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= (r_a[31] == r_b[31]) && (w_sum[7] != r_a[31]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_res;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_seq_adder_32b.sv
// Randomized bench for seq_adder_32b against a signed/unsigned arithmetic model.
module tb_seq_adder_32b;
  import seq_adder_32b_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        sub = 1'b0;
  logic        out_val;
  logic        out_rdy = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  seq_adder_32b dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy),
    .in0(in0), .in1(in1), .sub(sub), .out_val(out_val), .out_rdy(out_rdy),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Result as integers: unsigned borrow rule for cout, signed range for ovf.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb, sr, ur;
    logic c, v;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    sr = s ? la - lb : la + lb;
    ur = s ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
    c  = s ? (a >= b) : (ur > 64'sd4294967295);
    v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {v, c, sr[31:0]};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    in0 = a; in1 = b; sub = s; in_val = 1'b1;
    chk("in_rdy_pre", 32'(in_rdy), 32'd1);
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  task automatic finish_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    logic [33:0] m;
    int n;
    m = model(a, b, s);
    n = 1;
    while (!out_val && n < 20) begin
      in0 = $urandom; in1 = $urandom; sub = 1'($urandom); in_val = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_val = 1'b0;
    chk("latency", 32'(n), 32'(NUM_BYTES + 1));
    chk("sum", sum, m[31:0]);
    chk("cout", 32'(cout), 32'(m[32]));
    chk("ovf", 32'(ovf), 32'(m[33]));
    for (int h = 0; h < hold; h++) begin
      in0 = $urandom; in_val = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_val", 32'(out_val), 32'd1);
      chk("hold_rdy", 32'(in_rdy), 32'd0);
      chk("hold_sum", sum, m[31:0]);
      chk("hold_flags", {30'd0, ovf, cout}, {30'd0, m[33:32]});
    end
    in_val = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    chk("hs_val", 32'(out_val), 32'd0);
    chk("hs_rdy", 32'(in_rdy), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    @(negedge clk);
    start_op(a, b, s);
    finish_op(a, b, s, hold);
  endtask

  initial begin
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {30'd0, ovf, cout}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 3);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 2);

    // Abort mid-CALC with an asynchronous reset, then accept on the first edge after release.
    @(negedge clk);
    start_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_out_val", 32'(out_val), 32'd0);
    chk("arst_in_rdy", 32'(in_rdy), 32'd1);
    chk("arst_sum", sum, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_op(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
    chk("accept_after_rst", 32'(in_rdy), 32'd0);
    finish_op(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i % 8 == 0) b = a;
      run_op(a, b, s, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_adder_32b.md
SEQ_ADDER_32B -- requirements
Module: seq_adder_32b

Interface
REQ-001 SHALL have no parameters; width fixed at 32 b, processed as 4 bytes.
REQ-002 SHALL have port clk, input, 1 b, rising-edge clock.
REQ-003 SHALL have port rst, input, 1 b, reset, asynchronous and active-high.
REQ-004 SHALL have port in_val, input, 1 b, operand request valid.
REQ-005 SHALL have port in_rdy, output, 1 b, block ready to accept operands.
REQ-006 SHALL have port in0, input, 32 b, operand A.
REQ-007 SHALL have port in1, input, 32 b, operand B.
REQ-008 SHALL have port sub, input, 1 b: 0 = A+B, 1 = A-B.
REQ-009 SHALL have port out_val, output, 1 b, result valid.
REQ-010 SHALL have port out_rdy, input, 1 b, consumer ready.
REQ-011 SHALL have port sum, output, 32 b, result.
REQ-012 SHALL have port cout, output, 1 b, carry out of bit 31.
REQ-013 SHALL have port ovf, output, 1 b, signed overflow.

Function
REQ-014 SHALL implement states IDLE, CALC, DONE.
REQ-015 SHALL assert in_rdy only in IDLE, and out_val only in DONE.
REQ-016 On in_val && in_rdy, SHALL latch in0, in1 (inverted if sub=1) and sub, then SHALL set carry register = sub, byte index = 0, state = CALC.
REQ-017 In CALC, SHALL add byte[idx] of the latched A and B with the carry register on the single 8-bit adder.
REQ-018 In CALC, SHALL write the adder sum into result byte[idx], load adder cout into the carry register, and increment idx.
REQ-019 On the CALC cycle with idx = 3, SHALL capture cout = adder cout and ovf = (A[31] == B'[31]) && (sum[31] != A[31]), using the inverted B when sub=1, then SHALL go to DONE.
REQ-020 Latency SHALL be 4 CALC cycles: out_val rises exactly 5 rising edges after the accept edge, counting the accept edge.
REQ-021 In DONE, SHALL hold sum, cout and ovf stable while out_rdy = 0.
REQ-022 On out_val && out_rdy, SHALL go to IDLE; peak throughput is one operation per 6 cycles.
REQ-023 SHALL ignore in_val and operand changes outside IDLE; latched operands SHALL NOT change mid-operation.
REQ-024 SHALL ignore out_rdy outside DONE.
REQ-025 sum SHALL reflect the result register at all times; partial bytes are visible during CALC but qualified only by out_val.
REQ-026 Arithmetic SHALL wrap modulo 2^32; idx SHALL be 2 b and wrap 3 -> 0.

Reset
REQ-027 rst SHALL immediately force state = IDLE, idx = 0, carry = 0, result = 0, cout = 0, ovf = 0, in_rdy = 1 and out_val = 0, independent of clk.
REQ-028 rst asserted during CALC or DONE SHALL abort the operation with no result produced.
REQ-029 After rst deasserts, the first rising edge SHALL be able to accept a new request.

Structure
REQ-030 The state encoding (IDLE=0, CALC=1, DONE=2) and the byte count (4) SHALL be constants in the shared header, used by both RTL and bench.
REQ-031 SHALL instantiate exactly one 8-bit adder, AdderCarrySelect_8b_GL; all other logic (FSM, counter, registers, byte muxing) SHALL be local.

Verification
REQ-032 Reset check: assert rst mid-CALC -> out_val = 0, in_rdy = 1 and sum = 0 asynchronously; a new op is accepted on the edge after release.
REQ-033 Basic add: A = 0x0000_00FF, B = 0x0000_0001, sub = 0 -> sum = 0x0000_0100, cout = 0, ovf = 0, out_val exactly 5 edges after accept.
REQ-034 Carry chain: A = 0xFFFF_FFFF, B = 0x0000_0001 -> sum = 0, cout = 1, ovf = 0.
REQ-035 Signed overflow: A = 0x7FFF_FFFF, B = 1 -> sum = 0x8000_0000, ovf = 1.
REQ-036 Subtract with overflow: A = 0x8000_0000, B = 1, sub = 1 -> sum = 0x7FFF_FFFF, ovf = 1, cout = 1.
REQ-037 Backpressure: hold out_rdy = 0 for 3 cycles while toggling in_val and in0 -> outputs stable and in_rdy = 0; a back-to-back second op starts only after the handshake.
